instr_loader: RTL and testbench

Program loader that writes the instruction memory inside the IF stage. It accepts a byte stream over a valid/ready handshake, typically from the UART receiver, and packs it into 32-bit big-endian instruction words. Each word is driven onto IF's write port (`i_write_en`, `i_read_en`, `i_data`, `i_addr_wr`) at consecutive word addresses. While a load is in progress, the block holds the pipeline in reset and stall; it releases the pipeline once the program is complete.

---
 rtl/instr_loader.sv | 170 +++++++++++++++++
 tb/tb_instr_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// ---------------------------------------------------------------------------
// instr_loader
//
// Program loader for the IF-stage instruction memory. Bytes arrive over a
// valid/ready handshake (typically from the UART receiver). Each group of
// four is packed big-endian into a 32-bit word, and the word is written to
// IF at consecutive word addresses. The pipeline is held in reset/stall
// while a load is in progress. It is released once HALT_WORD has been
// written or the memory is full.
//
// Ports
//   i_clk         clock, rising edge
//   i_reset       synchronous reset, active low
//   i_start       begin a new load at address 0 (honoured in IDLE/DONE only)
//   i_byte_valid  i_byte carries a stream byte
//   i_byte        stream byte; the first byte of a word is bits [31:24]
//   o_byte_ready  loader accepts a byte this cycle
//   o_write_en    IF instruction-memory write enable
//   o_read_en     IF instruction-memory read enable (program ready to run)
//   o_data        word to write (valid while o_write_en)
//   o_addr_wr     byte address of the write, multiple of 4
//   o_cpu_hold    pipeline reset/stall while loading
//   o_done        a load has completed
//   o_trunc       load stopped at MAX_WORDS without seeing HALT_WORD
//   o_word_count  words written in the current or last load
// ---------------------------------------------------------------------------
module instr_loader #(
   parameter int unsigned MAX_WORDS = 256,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
   parameter int unsigned CNT_W     = $clog2(MAX_WORDS + 1)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_byte_valid,
   input  logic [7:0]       i_byte,
   output logic             o_byte_ready,
   output logic             o_write_en,
   output logic             o_read_en,
   output logic [31:0]      o_data,
   output logic [31:0]      o_addr_wr,
   output logic             o_cpu_hold,
   output logic             o_done,
   output logic             o_trunc,
   output logic [CNT_W-1:0] o_word_count
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RECV,
      ST_WRITE,
      ST_DONE
   } state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

   state_t           state_q;
   logic [1:0]       idx_q;
   // Only the first three bytes need buffering; the fourth byte is combined
   // with them directly into the output data register.
   logic [23:0]      word_q;
   logic [31:0]      addr_q;
   logic [CNT_W-1:0] count_q;

   logic             ready_q;
   logic             write_en_q;
   logic             read_en_q;
   logic [31:0]      data_q;
   logic [31:0]      addr_wr_q;
   logic             hold_q;
   logic             done_q;
   logic             trunc_q;

   logic [CNT_W-1:0] count_inc;
   logic [31:0]      word_full;
   logic             accept;

   assign count_inc = count_q + CNT_W'(1);
   assign word_full = {word_q, i_byte};
   assign accept    = i_byte_valid && ready_q;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         word_q     <= '0;
         addr_q     <= '0;
         count_q    <= '0;
         ready_q    <= 1'b0;
         write_en_q <= 1'b0;
         read_en_q  <= 1'b0;
         data_q     <= '0;
         addr_wr_q  <= '0;
         hold_q     <= 1'b1;
         done_q     <= 1'b0;
         trunc_q    <= 1'b0;
      end else begin
         write_en_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (i_start) begin
                  state_q   <= ST_RECV;
                  idx_q     <= '0;
                  addr_q    <= '0;
                  count_q   <= '0;
                  done_q    <= 1'b0;
                  trunc_q   <= 1'b0;
                  hold_q    <= 1'b1;
                  read_en_q <= 1'b0;
                  ready_q   <= 1'b1;
               end
            end

            ST_RECV: begin
               if (accept) begin
                  word_q <= word_full[23:0];
                  if (idx_q == 2'd3) begin
                     // Fourth byte: present the word and address on the
                     // write port during the single WRITE cycle.
                     idx_q      <= '0;
                     state_q    <= ST_WRITE;
                     ready_q    <= 1'b0;
                     write_en_q <= 1'b1;
                     data_q     <= word_full;
                     addr_wr_q  <= addr_q;
                  end else begin
                     idx_q <= idx_q + 2'd1;
                  end
               end
            end

            ST_WRITE: begin
               count_q <= count_inc;
               // Stop the address at the last word so it never points
               // past the memory.
               if (count_inc != MAX_CNT) begin
                  addr_q <= addr_q + 32'd4;
               end
               if (data_q == HALT_WORD || count_inc == MAX_CNT) begin
                  state_q   <= ST_DONE;
                  trunc_q   <= (data_q != HALT_WORD);
                  done_q    <= 1'b1;
                  hold_q    <= 1'b0;
                  read_en_q <= 1'b1;
                  ready_q   <= 1'b0;
               end else begin
                  state_q <= ST_RECV;
                  ready_q <= 1'b1;
               end
            end

            default: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign o_byte_ready = ready_q;
   assign o_write_en   = write_en_q;
   assign o_read_en    = read_en_q;
   assign o_data       = data_q;
   assign o_addr_wr    = addr_wr_q;
   assign o_cpu_hold   = hold_q;
   assign o_done       = done_q;
   assign o_trunc      = trunc_q;
   assign o_word_count = count_q;

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

   localparam int unsigned MW   = 4;
   localparam logic [31:0] HALT = 32'hFFFF_FFFF;
   localparam int unsigned CW   = $clog2(MW + 1);

   logic          clk = 1'b0;
   logic          i_reset = 1'b0;
   logic          i_start = 1'b0;
   logic          i_byte_valid = 1'b0;
   logic [7:0]    i_byte = '0;
   logic          o_byte_ready, o_write_en, o_read_en, o_cpu_hold, o_done, o_trunc;
   logic [31:0]   o_data, o_addr_wr;
   logic [CW-1:0] o_word_count;

   always #5 clk = ~clk;

   instr_loader #(.MAX_WORDS(MW), .HALT_WORD(HALT), .CNT_W(CW)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_start(i_start),
      .i_byte_valid(i_byte_valid), .i_byte(i_byte),
      .o_byte_ready(o_byte_ready), .o_write_en(o_write_en), .o_read_en(o_read_en),
      .o_data(o_data), .o_addr_wr(o_addr_wr), .o_cpu_hold(o_cpu_hold),
      .o_done(o_done), .o_trunc(o_trunc), .o_word_count(o_word_count)
   );

   int checks = 0;
   int errors = 0;

   // Behavioural model: words still expected to be written (in order),
   // how many have been written so far in this load, and a capture log.
   logic [31:0] exp_q[$];
   int unsigned wdone = 0;
   bit          prev_we = 0;
   bit          mon_en = 0;
   logic [31:0] cap_addr[$];
   logic [31:0] cap_data[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("word_count", 64'(o_word_count), 64'(wdone));
         chk("hold_vs_done", 64'(o_cpu_hold), 64'(!o_done));
         chk("read_en_vs_done", 64'(o_read_en), 64'(o_done));
         if (o_done) chk("ready_in_done", 64'(o_byte_ready), 64'd0);
         if (o_write_en) begin
            chk("write_pulse_width", 64'(prev_we), 64'd0);
            chk("ready_in_write", 64'(o_byte_ready), 64'd0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                        o_addr_wr, o_data);
            end else begin
               logic [31:0] w;
               w = exp_q.pop_front();
               chk("write_addr", 64'(o_addr_wr), 64'(wdone * 4));
               chk("write_data", 64'(o_data), 64'(w));
               cap_addr.push_back(o_addr_wr);
               cap_data.push_back(o_data);
               wdone++;
            end
         end
         prev_we = o_write_en;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      exp_q.delete();
      cap_addr.delete();
      cap_data.delete();
      wdone = 0;
      prev_we = 0;
   endtask

   task automatic do_reset();
      i_reset = 1'b0;
      tick();
      i_reset = 1'b1;
      clear_model();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_write_en"}, 64'(o_write_en), 64'd0);
      chk({tag, "_read_en"}, 64'(o_read_en), 64'd0);
      chk({tag, "_ready"}, 64'(o_byte_ready), 64'd0);
      chk({tag, "_hold"}, 64'(o_cpu_hold), 64'd1);
      chk({tag, "_done"}, 64'(o_done), 64'd0);
      chk({tag, "_trunc"}, 64'(o_trunc), 64'd0);
      chk({tag, "_count"}, 64'(o_word_count), 64'd0);
      chk({tag, "_data"}, 64'(o_data), 64'd0);
      chk({tag, "_addr"}, 64'(o_addr_wr), 64'd0);
   endtask

   task automatic do_start();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      clear_model();
      chk("start_done_clear", 64'(o_done), 64'd0);
      chk("start_hold_set", 64'(o_cpu_hold), 64'd1);
      chk("start_ready", 64'(o_byte_ready), 64'd1);
      chk("start_trunc_clear", 64'(o_trunc), 64'd0);
   endtask

   // Present each byte until the handshake completes. gap is the percent
   // chance of a cycle without valid; noise pulses i_start, which must be
   // ignored while loading.
   task automatic send_bytes(input logic [7:0] bytes[$], input int unsigned gap, input bit noise);
      foreach (bytes[i]) begin
         bit acc = 0;
         for (int unsigned c = 0; c < 200 && !acc; c++) begin
            i_byte_valid = ($urandom_range(0, 99) >= gap);
            i_byte       = i_byte_valid ? bytes[i] : 8'($urandom);
            i_start      = noise && ($urandom_range(0, 7) == 0);
            @(negedge clk);
            acc = i_byte_valid && o_byte_ready;
            tick();
         end
         if (!acc) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout: got no accept of byte %0d expected accept", i);
            i_byte_valid = 1'b0;
            i_start = 1'b0;
            return;
         end
      end
      i_byte_valid = 1'b0;
      i_start = 1'b0;
   endtask

   // Full load: model decides which words get written (stop after HALT or
   // after MW words), streams their bytes big-endian, then checks the end state.
   task automatic run_load(input logic [31:0] words[$], input int unsigned gap, input bit noise);
      logic [7:0]  bytes[$];
      int unsigned exp_cnt = 0;
      bit          exp_trunc = 0;
      bit          seen = 0;
      do_start();
      for (int unsigned i = 0; i < words.size(); i++) begin
         exp_q.push_back(words[i]);
         exp_cnt++;
         for (int unsigned b = 0; b < 4; b++) bytes.push_back(8'(words[i] >> (24 - 8 * b)));
         if (words[i] == HALT) break;
         if (exp_cnt == MW) begin
            exp_trunc = 1;
            break;
         end
      end
      send_bytes(bytes, gap, noise);
      for (int unsigned c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         seen = o_done;
      end
      tick();
      chk("end_done", 64'(o_done), 64'd1);
      chk("end_trunc", 64'(o_trunc), 64'(exp_trunc));
      chk("end_count", 64'(o_word_count), 64'(exp_cnt));
      chk("end_hold", 64'(o_cpu_hold), 64'd0);
      chk("end_read_en", 64'(o_read_en), 64'd1);
      chk("end_pending_writes", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      logic [31:0] ws[$];
      logic [7:0]  part[$];

      // Reset, then idle with i_start low.
      tick();
      tick();
      i_reset = 1'b1;
      mon_en = 1;
      repeat (10) tick();
      check_reset_outputs("idle");

      // Basic two-word program, valid held high.
      ws = '{32'h014B4820, HALT};
      run_load(ws, 0, 0);
      chk("lit_addr0", 64'(cap_addr[0]), 64'h0);
      chk("lit_data0", 64'(cap_data[0]), 64'h014B4820);
      chk("lit_addr1", 64'(cap_addr[1]), 64'h4);
      chk("lit_data1", 64'(cap_data[1]), 64'hFFFFFFFF);
      chk("lit_count", 64'(o_word_count), 64'd2);

      // Same stream with gaps in valid.
      run_load(ws, 50, 0);
      chk("gap_data0", 64'(cap_data[0]), 64'h014B4820);
      chk("gap_nwrites", 64'(cap_data.size()), 64'd2);

      // Memory-full truncation.
      ws = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      run_load(ws, 20, 0);
      chk("trunc_last_addr", 64'(cap_addr[3]), 64'hC);
      chk("trunc_flag", 64'(o_trunc), 64'd1);
      chk("trunc_count", 64'(o_word_count), 64'd4);

      // Reset after two bytes of the first word.
      do_start();
      part = '{8'hAA, 8'hBB};
      send_bytes(part, 0, 0);
      do_reset();
      check_reset_outputs("midreset");
      ws = '{32'h12345678, HALT};
      run_load(ws, 0, 0);
      chk("fresh_addr0", 64'(cap_addr[0]), 64'h0);
      chk("fresh_data0", 64'(cap_data[0]), 64'h12345678);

      // Restart from DONE.
      ws = '{32'h00000000, HALT};
      run_load(ws, 10, 0);
      chk("restart_addr1", 64'(cap_addr[1]), 64'h4);
      chk("restart_count", 64'(o_word_count), 64'd2);

      // Randomized loads, including stray i_start pulses while loading.
      for (int unsigned n = 0; n < 30; n++) begin
         ws.delete();
         for (int unsigned k = 0; k < MW; k++) begin
            logic [31:0] w;
            w = ($urandom_range(0, 3) == 0) ? HALT : $urandom;
            ws.push_back(w);
            if (w == HALT) break;
         end
         run_load(ws, $urandom_range(0, 60), n[0]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
